// File: rtl/seg_pkg.sv
// Shared types, constants and hex decode table
// for the 4-digit seven-segment scan controller.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low cathodes, bit 0 = segment a ... bit 6 = segment g
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        s = SEG_OFF;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble to active-low
// seven-segment pattern.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex2seg(hex);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner
// with dead time, leading-zero blanking and tear-free loads.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int LZ_BLANK  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    dig;
    logic [1:0]    dig_nxt;
    state_t        st;
    state_t        st_nxt;

    logic [15:0]   disp;
    logic [3:0]    disp_dp;
    logic [15:0]   pend;
    logic [3:0]    pend_dp;
    logic          pend_full;

    logic          slot_end;
    logic          accept;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic [3:0]    lz;

    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    assign slot_end   = (cnt == CW'(SCAN_DIV - 1));
    assign frame_tick = slot_end && (dig == 2'd3);
    assign load_ready = !pend_full;
    assign accept     = load_valid && load_ready;

    always_comb begin
        cnt_nxt = cnt + 1'b1;
        dig_nxt = dig;
        if (slot_end) begin
            cnt_nxt = '0;
            dig_nxt = dig + 2'd1;
        end
        st_nxt = (cnt_nxt < CW'(BLANK_CYC)) ? BLANK : DRIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            dig <= 2'd0;
            st  <= BLANK;
        end else begin
            cnt <= cnt_nxt;
            dig <= dig_nxt;
            st  <= st_nxt;
        end
    end

    assign nib = disp[{dig, 2'b00} +: 4];

    seg_decoder u_dec (
        .hex (nib),
        .seg (dec)
    );

    // A digit blanks only when it and every digit above it is zero
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (LZ_BLANK != 0) && (disp[15:12] == 4'h0);
        lz[2] = lz[3] && (disp[11:8] == 4'h0);
        lz[1] = lz[2] && (disp[7:4] == 4'h0);
    end

    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        unique case (st)
            BLANK: begin
                an_nxt  = 4'b1111;
            end
            DRIVE: begin
                an_nxt  = ~(4'b0001 << dig);
                seg_nxt = lz[dig] ? SEG_OFF : dec;
                dp_nxt  = ~disp_dp[dig];
            end
            default: begin
                an_nxt  = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

    // Display only changes at the frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp      <= 16'h0000;
            disp_dp   <= 4'h0;
            pend      <= 16'h0000;
            pend_dp   <= 4'h0;
            pend_full <= 1'b0;
        end else begin
            if (frame_tick && pend_full) begin
                disp      <= pend;
                disp_dp   <= pend_dp;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend      <= load_data;
                pend_dp   <= load_dp;
                pend_full <= 1'b1;
            end
        end
    end

    param_ok: assert property (
        @(posedge clk) (BLANK_CYC >= 1) && (BLANK_CYC < SCAN_DIV)
    );

endmodule
